alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_shifter.sv | 95 +++++++++
 rtl/alu_exec_unit.sv | 143 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, FSM state type and decode helpers
//
// Shared by the ALU control decoder and alu_exec_unit.
// Contents:
//   ALU_* 4-bit control codes
//   alu_state_t   execution FSM states (IDLE, SHIFT, DONE)
//   SH_* codes    shift kinds passed to alu_shifter
//   is_shift_code / shift_kind_of decode helpers
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_t;

  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;

  function automatic logic is_shift_code(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

  function automatic logic [1:0] shift_kind_of(input logic [3:0] code);
    logic [1:0] kind;
    case (code)
      ALU_SLL: kind = SH_SLL;
      ALU_SRL: kind = SH_SRL;
      default: kind = SH_SRA;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - logical/arithmetic shifter, iterative or barrel
//
// Build option: ALU_BARREL_SHIFT_EN selects a single-cycle barrel shifter;
// otherwise an iterative shifter moving one bit per clock is built.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (iterative build only)
//   start       pulse on the accept edge of a shift operation
//   kind        SH_SLL / SH_SRL / SH_SRA
//   din         value to shift (op_a)
//   shamt       shift amount
//   dout        shifted value; valid when last is high
//   last        this cycle's step completes the shift
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       kind,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] dout,
  output logic             last
);

`ifdef ALU_BARREL_SHIFT_EN

  logic unused_barrel;
  assign unused_barrel = ^{clk, rst_n, start};

  always_comb begin
    case (kind)
      SH_SLL:  dout = din << shamt;
      SH_SRL:  dout = din >> shamt;
      default: dout = $unsigned($signed(din) >>> shamt);
    endcase
    last = 1'b1;
  end

`else

  localparam logic [SHW-1:0] ONE = SHW'(1);

  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       kind_q, kind_d;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] step;
  logic [1:0]       cur_kind;

  // On the accept edge the first step is taken straight from din, so a
  // shift by N finishes N-1 cycles later; cnt_q counts the remaining steps.
  always_comb begin
    src      = start ? din  : work_q;
    cur_kind = start ? kind : kind_q;
    case (cur_kind)
      SH_SLL:  step = {src[WIDTH-2:0], 1'b0};
      SH_SRL:  step = {1'b0, src[WIDTH-1:1]};
      default: step = {src[WIDTH-1], src[WIDTH-1:1]};
    endcase

    work_d = work_q;
    cnt_d  = cnt_q;
    kind_d = kind_q;
    if (start) begin
      work_d = step;
      kind_d = kind;
      cnt_d  = (shamt == '0) ? '0 : shamt - ONE;
    end else if (cnt_q != '0) begin
      work_d = step;
      cnt_d  = cnt_q - ONE;
    end

    dout = (start && (shamt == '0)) ? din : step;
    last = start ? (shamt <= ONE) : (cnt_q == ONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      cnt_q  <= '0;
      kind_q <= SH_SLL;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      kind_q <= kind_d;
    end
  end

`endif

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - handshaked ALU execution unit (add/sub/and/or/shifts)
//
// Build option: ALU_BARREL_SHIFT_EN makes every operation single-latency.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operation request handshake
//   alu_ctrl, op_a, op_b  operation code and operands (op_b[SHW-1:0] = shamt)
//   out_valid / out_ready result handshake
//   result, zero, illegal result value, result==0 flag, unsupported-code flag
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic             is_shift;
  logic             sh_start;
  logic [WIDTH-1:0] sh_dout;
  logic             sh_last;

  assign accept   = in_valid && in_ready;
  assign is_shift = is_shift_code(alu_ctrl);
  assign sh_start = accept && is_shift;

  alu_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (sh_start),
    .kind  (shift_kind_of(alu_ctrl)),
    .din   (op_a),
    .shamt (op_b[SHW-1:0]),
    .dout  (sh_dout),
    .last  (sh_last)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (is_shift && !sh_last) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (sh_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Result datapath: loaded at acceptance, or on the final shift step.
  // Registers otherwise hold, which keeps outputs stable during DONE.
  always_comb begin
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    if (accept) begin
      illegal_d = 1'b0;
      case (alu_ctrl)
        ALU_ADD: result_d = op_a + op_b;
        ALU_SUB: result_d = op_a - op_b;
        ALU_AND: result_d = op_a & op_b;
        ALU_OR:  result_d = op_a | op_b;
        ALU_SLL, ALU_SRL, ALU_SRA: begin
          if (sh_last) begin
            result_d = sh_dout;
          end
        end
        default: begin
          result_d  = '0;
          illegal_d = 1'b1;
        end
      endcase
      zero_d = (result_d == '0);
    end else if ((state_q == SHIFT) && sh_last) begin
      result_d = sh_dout;
      zero_d   = (sh_dout == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int vectors;
  int miscompares;

`ifdef ALU_BARREL_SHIFT_EN
  localparam int LAT_SRA4  = 1;
  localparam int LAT_SLL31 = 1;
`else
  localparam int LAT_SRA4  = 4;
  localparam int LAT_SLL31 = 31;
`endif

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request, scrambles inputs after the accept edge, and returns
  // the number of cycles until out_valid (0 if it never arrives).
  task automatic issue(input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, output int lat);
    @(negedge clk);
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_ctrl = 4'b0010;
    op_a     = 32'hDEADBEEF;
    op_b     = 32'h12345678;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++;
    if (result !== 32'h0) begin miscompares++; $display("FAIL reset_result got %h want 00000000", result); end
    vectors++;
    if (zero !== 1'b0) begin miscompares++; $display("FAIL reset_zero got %b want 0", zero); end
    vectors++;
    if (illegal !== 1'b0) begin miscompares++; $display("FAIL reset_illegal got %b want 0", illegal); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    out_ready = 1'b1;
    issue(4'b0010, 32'h7FFFFFFF, 32'h00000001, lat);
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL add_latency got %0d want 1", lat); end
    vectors++;
    if (result !== 32'h80000000) begin miscompares++; $display("FAIL add_result got %h want 80000000", result); end
    vectors++;
    if (zero !== 1'b0 || illegal !== 1'b0) begin miscompares++; $display("FAIL add_flags got zero=%b illegal=%b want 0 0", zero, illegal); end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL add_release got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_sub_sra();
    int lat;
    out_ready = 1'b1;
    issue(4'b0110, 32'd5, 32'd5, lat);
    vectors++;
    if (lat !== 1 || result !== 32'h0 || zero !== 1'b1) begin
      miscompares++; $display("FAIL sub_zero got lat=%0d result=%h zero=%b want 1 00000000 1", lat, result, zero);
    end
    issue(4'b1011, 32'h80000000, 32'd4, lat);
    vectors++;
    if (lat !== LAT_SRA4) begin miscompares++; $display("FAIL sra_latency got %0d want %0d", lat, LAT_SRA4); end
    vectors++;
    if (result !== 32'hF8000000 || zero !== 1'b0) begin miscompares++; $display("FAIL sra_result got %h zero=%b want f8000000 0", result, zero); end
  endtask

  task automatic test_hold();
    int  lat;
    logic bad_ready;
    logic bad_hold;
    @(negedge clk);
    out_ready = 1'b0;
    alu_ctrl  = 4'b1000;
    op_a      = 32'h1;
    op_b      = 32'd31;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a     = 32'hFFFFFFFF;
    op_b     = 32'd3;
    lat = 0;
    bad_ready = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0) bad_ready = 1'b1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    vectors++;
    if (lat !== LAT_SLL31) begin miscompares++; $display("FAIL sll31_latency got %0d want %0d", lat, LAT_SLL31); end
    bad_hold = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (in_ready !== 1'b0) bad_ready = 1'b1;
      if (out_valid !== 1'b1 || result !== 32'h80000000 || zero !== 1'b0 || illegal !== 1'b0) bad_hold = 1'b1;
    end
    vectors++;
    if (bad_ready !== 1'b0) begin miscompares++; $display("FAIL sll31_in_ready got high want 0 while busy"); end
    vectors++;
    if (bad_hold !== 1'b0) begin miscompares++; $display("FAIL sll31_hold got result=%h out_valid=%b want 80000000 1", result, out_valid); end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL sll31_release got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_illegal();
    int lat;
    out_ready = 1'b1;
    issue(4'b1111, 32'h1234, 32'h5678, lat);
    vectors++;
    if (lat !== 1 || result !== 32'h0 || zero !== 1'b1 || illegal !== 1'b1) begin
      miscompares++; $display("FAIL illegal_code got lat=%0d result=%h zero=%b illegal=%b want 1 00000000 1 1", lat, result, zero, illegal);
    end
    issue(4'b1001, 32'h000000F0, 32'd0, lat);
    vectors++;
    if (lat !== 1 || result !== 32'h000000F0 || illegal !== 1'b0 || zero !== 1'b0) begin
      miscompares++; $display("FAIL srl_by0 got lat=%0d result=%h illegal=%b want 1 000000f0 0", lat, result, illegal);
    end
  endtask

  task automatic test_reset_mid_shift();
    int  lat;
    logic stray;
    out_ready = 1'b1;
    @(negedge clk);
    alu_ctrl = 4'b1001;
    op_a     = 32'hFFFFFFFF;
    op_b     = 32'd20;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
      miscompares++; $display("FAIL async_reset got out_valid=%b in_ready=%b result=%h want 0 1 00000000", out_valid, in_ready, result);
    end
    repeat (2) @(negedge clk);
    // Release and request on the same cycle: accepted on the first rising edge.
    rst_n    = 1'b1;
    alu_ctrl = 4'b0010;
    op_a     = 32'd3;
    op_b     = 32'd4;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    vectors++;
    if (lat !== 1 || result !== 32'd7) begin miscompares++; $display("FAIL post_reset_add got lat=%0d result=%h want 1 00000007", lat, result); end
    stray = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray = 1'b1;
    end
    vectors++;
    if (stray !== 1'b0) begin miscompares++; $display("FAIL aborted_result got out_valid=1 want no delivery"); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    @(negedge clk);
    alu_ctrl = 4'b0010;
    op_a     = 32'd1;
    op_b     = 32'd2;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    alu_ctrl = 4'b0110;
    op_a     = 32'd10;
    op_b     = 32'd3;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd3) begin
      miscompares++; $display("FAIL b2b_first got out_valid=%b in_ready=%b result=%h want 1 0 00000003", out_valid, in_ready, result);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd3) begin
      miscompares++; $display("FAIL b2b_gap got out_valid=%b in_ready=%b result=%h want 0 1 00000003", out_valid, in_ready, result);
    end
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || result !== 32'd7) begin
      miscompares++; $display("FAIL b2b_second got out_valid=%b result=%h want 1 00000007", out_valid, result);
    end
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    alu_ctrl    = 4'b0000;
    op_a        = 32'h0;
    op_b        = 32'h0;
    test_reset();
    test_add();
    test_sub_sra();
    test_hold();
    test_illegal();
    test_reset_mid_shift();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
